opb_register_simulink2ppc: RTL and testbench

//  Reverse-direction companion of the ppc2simulink register: user (Simulink) logic posts a 32-bit word,

---
 rtl/opb_reg_pkg.sv | 23 ++
 rtl/opb_slave_decode.sv | 65 ++++++
 rtl/opb_register_simulink2ppc.sv | 107 ++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register slaves: word offsets, status bit positions and the
// slave-handshake state encoding.
package opb_reg_pkg;

    localparam logic [7:0] OFS_DATA   = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;

    // Status bit positions in OPB big-endian numbering (bit 31 is the LSB).
    localparam int unsigned ST_NEW = 31;
    localparam int unsigned ST_OVF = 30;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWait
    } opb_state_e;

    // Converts an OPB big-endian bit number into a descending vector index.
    function automatic int unsigned opb_idx(input int unsigned opb_bit, input int unsigned width);
        return width - 1 - opb_bit;
    endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave address decode and IDLE/ACK/WAIT handshake: one registered ack per select assertion,
// with single-cycle read/write strobes in the cycle that starts the transfer.
module opb_slave_decode
    import opb_reg_pkg::*;
#(
    parameter int unsigned    AWidth   = 32,
    parameter logic [AWidth-1:0] BaseAddr = 32'h01014C00,
    parameter logic [AWidth-1:0] HighAddr = 32'h01014CFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AWidth-1:0] abus_i,
    input  logic              select_i,
    input  logic              rnw_i,
    output logic              ack_o,
    output logic              rd_stb_o,
    output logic              wr_stb_o,
    output logic [7:0]        offset_o
);

    opb_state_e state_q;
    logic       ack_q;
    logic       armed_q;
    logic       hit;
    logic       start;
    logic [7:0] rel_byte;

    // armed_q blocks a select that was already asserted across reset from starting a transfer.
    assign hit      = select_i & armed_q & (abus_i >= BaseAddr) & (abus_i <= HighAddr);
    assign start    = (state_q == StIdle) & hit;
    assign rd_stb_o = start & rnw_i;
    assign wr_stb_o = start & ~rnw_i;
    assign rel_byte = abus_i[7:0] - BaseAddr[7:0];
    assign offset_o = rel_byte & 8'hFC;
    assign ack_o    = ack_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (!select_i) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end
                end
                StAck: state_q <= StWait;
                StWait: begin
                    if (!select_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// User-to-PowerPC mailbox register: user logic posts a word, software reads it over OPB and polls a
// NEW/OVF status word (write-1-to-clear) so samples are neither missed nor double-counted.
module opb_register_simulink2ppc
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h01014C00,
    parameter logic [31:0] C_HIGHADDR    = 32'h01014CFF,
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter bit          C_CLR_ON_READ = 1'b1,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [C_OPB_AWIDTH-1:0] OPB_ABus,
    input  logic [3:0]              OPB_BE,
    input  logic [C_OPB_DWIDTH-1:0] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_ready
);

    localparam int unsigned NewIdx = opb_idx(ST_NEW, C_OPB_DWIDTH);
    localparam int unsigned OvfIdx = opb_idx(ST_OVF, C_OPB_DWIDTH);
    localparam string       unused_family = C_FAMILY;

    logic                    rd_stb;
    logic                    wr_stb;
    logic [7:0]              offset;
    logic [31:0]             data_q;
    logic                    new_q;
    logic                    ovf_q;
    logic [C_OPB_DWIDTH-1:0] dbus_q;
    logic [C_OPB_DWIDTH-1:0] dbus_d;
    logic                    status_wr;
    logic                    clr_new;
    logic                    clr_ovf;
    logic                    unused_inputs;

    opb_slave_decode #(
        .AWidth   (C_OPB_AWIDTH),
        .BaseAddr (C_BASEADDR),
        .HighAddr (C_HIGHADDR)
    ) u_decode (
        .clk_i    (OPB_Clk),
        .rst_ni   (OPB_Rst_n),
        .abus_i   (OPB_ABus),
        .select_i (OPB_select),
        .rnw_i    (OPB_RNW),
        .ack_o    (Sl_xferAck),
        .rd_stb_o (rd_stb),
        .wr_stb_o (wr_stb),
        .offset_o (offset)
    );

    // OPB BE[3] (bits 24..31) is the least-significant byte lane, vector index 0 here.
    assign status_wr = wr_stb & (offset == OFS_STATUS) & OPB_BE[0];
    assign clr_new   = (status_wr & OPB_DBus[NewIdx])
                     | (C_CLR_ON_READ & rd_stb & (offset == OFS_DATA));
    assign clr_ovf   = status_wr & OPB_DBus[OvfIdx];

    always_comb begin
        dbus_d = '0;
        if (rd_stb) begin
            if (offset == OFS_DATA) begin
                dbus_d = C_OPB_DWIDTH'(data_q);
            end else if (offset == OFS_STATUS) begin
                dbus_d[NewIdx] = new_q;
                dbus_d[OvfIdx] = ovf_q;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovf_q  <= 1'b0;
            dbus_q <= '0;
        end else begin
            dbus_q <= dbus_d;
            // A same-cycle clear of NEW counts as consumption, so capture does not flag overflow.
            ovf_q  <= (ovf_q & ~clr_ovf) | (user_valid & new_q & ~clr_new);
            new_q  <= user_valid | (new_q & ~clr_new);
            if (user_valid) begin
                data_q <= user_data_in;
            end
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_ready = ~new_q;

    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[3:1], OPB_DBus};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Randomized self-checking bench for opb_register_simulink2ppc against a mailbox-level model.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] Base = 32'h01014C00;
    localparam logic [31:0] High = 32'h01014CFF;
    localparam logic [31:0] AData = Base + 32'h0;
    localparam logic [31:0] AStat = Base + 32'h4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] abus = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rnw = 1'b0;
    logic        select = 1'b0;
    logic        seq_addr = 1'b0;
    logic [31:0] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] udata = '0;
    logic        uvalid = 1'b0;
    logic        uready;

    int checks = 0;
    int errors = 0;

    // Mailbox model: last posted word, unread flag, sticky overflow flag.
    logic [31:0] m_data = '0;
    logic        m_new = 1'b0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    opb_register_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (wdata),
        .OPB_RNW      (rnw),
        .OPB_select   (select),
        .OPB_seqAddr  (seq_addr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_ack),
        .Sl_errAck    (sl_err),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout),
        .user_data_in (udata),
        .user_valid   (uvalid),
        .user_ready   (uready)
    );

    function automatic logic [31:0] m_status();
        return {30'b0, m_ovf, m_new};
    endfunction

    task automatic opb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        @(negedge clk);
        abus = addr; rnw = 1'b1; select = 1'b1;
        lat = 99; data = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (sl_ack) begin
                lat = i; data = sl_dbus;
                break;
            end
        end
        select = 1'b0; rnw = 1'b0;
        @(negedge clk);
    endtask

    task automatic opb_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] b,
                             output int lat);
        @(negedge clk);
        abus = addr; rnw = 1'b0; wdata = d; be = b; select = 1'b1;
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (sl_ack) begin
                lat = i;
                break;
            end
        end
        select = 1'b0; be = '0; wdata = '0;
        @(negedge clk);
    endtask

    task automatic user_post(input logic [31:0] d);
        @(negedge clk);
        uvalid = 1'b1; udata = d;
        @(negedge clk);
        uvalid = 1'b0;
        if (m_new) m_ovf = 1'b1;
        m_new = 1'b1; m_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sl_ack !== 1'b0 || sl_dbus !== 32'h0 || uready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dbus=%h ready=%b, required ack=0 dbus=0 ready=1",
                     sl_ack, sl_dbus, uready);
        end
        checks++;
        if ({sl_err, sl_retry, sl_tout} !== 3'b000) begin
            errors++;
            $display("FAIL tied_outputs: got %b required 000", {sl_err, sl_retry, sl_tout});
        end
        rst_n = 1'b1;
        m_data = '0; m_new = 1'b0; m_ovf = 1'b0;
        @(negedge clk);
        begin
            logic [31:0] d; int lat;
            opb_read(AStat, d, lat);
            checks++;
            if (d !== 32'h0 || lat !== 1) begin
                errors++;
                $display("FAIL reset_status: got %h lat %0d, required 00000000 lat 1", d, lat);
            end
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] d; int lat;
        user_post(32'hDEADBEEF);
        checks++;
        if (uready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_post: got %b required 0", uready);
        end
        opb_read(AData, d, lat);
        m_new = 1'b0;
        checks++;
        if (d !== 32'hDEADBEEF || lat !== 1) begin
            errors++;
            $display("FAIL data_read: got %h lat %0d, required deadbeef lat 1", d, lat);
        end
        opb_read(AStat, d, lat);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL status_after_read: got %h required %h", d, m_status());
        end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] d; int lat;
        user_post(32'h1);
        user_post(32'h2);
        opb_read(AStat, d, lat);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL ovf_status: got %h required 00000003", d);
        end
        opb_write(AStat, 32'h2, 4'b0001, lat);
        m_ovf = 1'b0;
        opb_read(AStat, d, lat);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL clear_ovf: got %h required 00000001", d);
        end
        opb_write(AStat, 32'h1, 4'b0000, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL write_ack_no_be: lat %0d required 1", lat);
        end
        opb_read(AStat, d, lat);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL be_gated_clear: got %h required 00000001", d);
        end
        opb_read(AData, d, lat);
        m_new = 1'b0;
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL ovf_data: got %h required 00000002", d);
        end
    endtask

    task automatic test_set_vs_clear();
        logic [31:0] d; int lat;
        user_post(32'h44);
        @(negedge clk);
        abus = AStat; rnw = 1'b0; wdata = 32'h1; be = 4'b0001; select = 1'b1;
        uvalid = 1'b1; udata = 32'h55;
        @(negedge clk);
        uvalid = 1'b0;
        checks++;
        if (sl_ack !== 1'b1) begin
            errors++;
            $display("FAIL clear_write_ack: got %b required 1", sl_ack);
        end
        select = 1'b0; be = '0; wdata = '0;
        @(negedge clk);
        m_new = 1'b1; m_data = 32'h55;
        opb_read(AStat, d, lat);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL set_wins: status %h required 00000001", d);
        end
        opb_read(AData, d, lat);
        m_new = 1'b0;
        checks++;
        if (d !== 32'h55) begin
            errors++;
            $display("FAIL set_wins_data: got %h required 00000055", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; int lat;
        user_post(32'h10);
        @(negedge clk);
        abus = AData; rnw = 1'b1; select = 1'b1;
        uvalid = 1'b1; udata = 32'h20;
        @(negedge clk);
        uvalid = 1'b0;
        checks++;
        if (sl_ack !== 1'b1 || sl_dbus !== 32'h10) begin
            errors++;
            $display("FAIL read_vs_capture: ack=%b dbus=%h required ack=1 dbus=00000010",
                     sl_ack, sl_dbus);
        end
        select = 1'b0; rnw = 1'b0;
        @(negedge clk);
        m_data = 32'h20; m_new = 1'b1;
        opb_read(AStat, d, lat);
        checks++;
        if (d !== m_status()) begin
            errors++;
            $display("FAIL read_vs_capture_status: got %h required %h", d, m_status());
        end
    endtask

    task automatic test_select_hold();
        int acks;
        acks = 0;
        @(negedge clk);
        abus = AStat; rnw = 1'b1; select = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        select = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL single_ack: got %0d acks required 1", acks);
        end
        foreach (abus[i]) if (i < 2) begin
            @(negedge clk);
            abus = (i == 0) ? High + 32'h4 : Base - 32'h4;
            rnw = 1'b1; select = 1'b1;
            repeat (4) begin
                @(negedge clk);
                checks++;
                if (sl_ack !== 1'b0 || sl_dbus !== 32'h0) begin
                    errors++;
                    $display("FAIL out_of_range: addr %h ack=%b dbus=%h required 0/0",
                             abus, sl_ack, sl_dbus);
                end
            end
            select = 1'b0; rnw = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] d; int lat; int acks;
        user_post(32'h77);
        @(negedge clk);
        abus = AStat; rnw = 1'b1; select = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sl_ack !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ack: got %b required 1", sl_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sl_ack !== 1'b0 || sl_dbus !== 32'h0) begin
            errors++;
            $display("FAIL ack_drop_on_reset: ack=%b dbus=%h required 0/0", sl_ack, sl_dbus);
        end
        m_data = '0; m_new = 1'b0; m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL stale_select: got %0d acks required 0", acks);
        end
        select = 1'b0; rnw = 1'b0;
        @(negedge clk);
        opb_read(AStat, d, lat);
        checks++;
        if (d !== 32'h0 || lat !== 1 || uready !== 1'b1) begin
            errors++;
            $display("FAIL fresh_select: got %h lat %0d ready %b, required 0 lat 1 ready 1",
                     d, lat, uready);
        end
    endtask

    task automatic test_random();
        logic [31:0] d; logic [31:0] exp; int lat;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: user_post($urandom);
                1: begin
                    exp = m_data;
                    opb_read(AData, d, lat);
                    m_new = 1'b0;
                    checks++;
                    if (d !== exp || lat !== 1) begin
                        errors++;
                        $display("FAIL rnd_data: got %h lat %0d required %h lat 1", d, lat, exp);
                    end
                end
                2: begin
                    exp = m_status();
                    opb_read(AStat, d, lat);
                    checks++;
                    if (d !== exp || lat !== 1) begin
                        errors++;
                        $display("FAIL rnd_status: got %h lat %0d required %h lat 1", d, lat, exp);
                    end
                end
                3: begin
                    logic [1:0] bits; logic [3:0] b;
                    bits = 2'($urandom_range(0, 3));
                    b = 4'($urandom_range(0, 15));
                    opb_write(AStat, {$urandom_range(0, 1) ? 30'h3FFFFFFF : 30'h0, bits}, b, lat);
                    if (b[0] && bits[0]) m_new = 1'b0;
                    if (b[0] && bits[1]) m_ovf = 1'b0;
                    checks++;
                    if (lat !== 1) begin
                        errors++;
                        $display("FAIL rnd_write_ack: lat %0d required 1", lat);
                    end
                end
                default: begin
                    opb_read(Base + 32'($urandom_range(2, 63) * 4), d, lat);
                    checks++;
                    if (d !== 32'h0 || lat !== 1) begin
                        errors++;
                        $display("FAIL rnd_unmapped: got %h lat %0d required 0 lat 1", d, lat);
                    end
                end
            endcase
            checks++;
            if (uready !== ~m_new) begin
                errors++;
                $display("FAIL rnd_ready: got %b required %b", uready, ~m_new);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_overflow_clear();
        test_set_vs_clear();
        test_back_to_back();
        test_select_hold();
        test_reset_mid_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
